// File: rtl/bus_response_mux.sv
// Response multiplexer between the CPU memory port and the device slots.
// It latches the decoder select, handshakes with one device, and returns data or an error word.
module bus_response_mux #(
   parameter int          NDEV     = 8,
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_valid,
   input  logic [NDEV-1:0]      enables,
   output logic                 mem_ready,
   output logic [31:0]          mem_rdata,
   output logic                 bus_error,
   output logic [NDEV-1:0]      dev_valid,
   input  logic [NDEV-1:0]      dev_ready,
   input  logic [32*NDEV-1:0]   dev_rdata,
   output logic [7:0]           err_count
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_reg;
   logic [TW-1:0]   timer_reg;
   logic [NDEV-1:0] lowest_sel;
   logic            sel_hit;
   logic [31:0]     sel_rdata;
   logic [31:0]     masked_rdata [NDEV];

   // Two's-complement trick isolates the lowest set enable bit.
   assign lowest_sel = enables & (~enables + NDEV'(1));

   // dev_valid holds the latched one-hot select for the whole WAIT phase.
   assign sel_hit = |(dev_ready & dev_valid);

   generate
      for (genvar gi = 0; gi < NDEV; gi++) begin : g_mask
         assign masked_rdata[gi] = dev_rdata[32*gi +: 32] & {32{dev_valid[gi]}};
      end
   endgenerate

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NDEV; i++) begin
         sel_rdata = sel_rdata | masked_rdata[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         timer_reg <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         bus_error <= 1'b0;
         dev_valid <= '0;
         err_count <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               timer_reg <= '0;
               if (mem_valid && !mem_ready) begin
                  if (|enables) begin
                     dev_valid <= lowest_sel;
                     state_reg <= WAIT;
                  end else begin
                     mem_rdata <= ERR_DATA;
                     state_reg <= RESP;
                  end
               end
            end
            WAIT: begin
               if (!mem_valid) begin
                  // CPU abort: drop the request silently, any late ready is never looked at.
                  dev_valid <= '0;
                  timer_reg <= '0;
                  state_reg <= IDLE;
               end else if (sel_hit) begin
                  mem_rdata <= sel_rdata;
                  bus_error <= 1'b0;
                  dev_valid <= '0;
                  mem_ready <= 1'b1;
                  state_reg <= RESP;
               end else if (TIMEOUT != 0 && timer_reg == TW'(TIMEOUT - 1)) begin
                  mem_rdata <= ERR_DATA;
                  bus_error <= 1'b1;
                  dev_valid <= '0;
                  mem_ready <= 1'b1;
                  state_reg <= RESP;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            RESP: begin
               if (!mem_ready) begin
                  // Unmapped access arrives here one cycle early; raise the pulse now.
                  mem_ready <= 1'b1;
                  bus_error <= 1'b1;
               end else begin
                  mem_ready <= 1'b0;
                  bus_error <= 1'b0;
                  timer_reg <= '0;
                  state_reg <= IDLE;
                  if (bus_error && err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_response_mux.sv
// Self-checking bench for bus_response_mux: directed vector table, randomized
// transactions against a transaction-level model, saturation and mid-transaction reset.
module tb_bus_response_mux;
   localparam int          NDEV = 8;
   localparam int          TMO  = 4;
   localparam logic [31:0] ERR  = 32'hDEADBEEF;

   logic                clk = 1'b0;
   logic                reset;
   logic                mem_valid;
   logic [NDEV-1:0]     enables;
   logic                mem_ready;
   logic [31:0]         mem_rdata;
   logic                bus_error;
   logic [NDEV-1:0]     dev_valid;
   logic [NDEV-1:0]     dev_ready;
   logic [32*NDEV-1:0]  dev_rdata;
   logic [7:0]          err_count;

   int          checks = 0;
   int          errors = 0;
   int          model_errs = 0;
   logic [31:0] last_rdata = '0;

   typedef struct {
      logic [7:0] en;
      int         lat;       // cycles after dev_valid before the selected device answers
      int         abort_at;  // cycle in which the CPU drops mem_valid, 0 = no abort
      logic [7:0] noise;     // non-selected dev_ready bits allowed to toggle
      logic [7:0] exp_sel;
      int         exp_resp;  // cycle of mem_ready, counted from acceptance
      logic       exp_err;
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   bus_response_mux #(.NDEV(NDEV), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (mem_valid),
      .enables   (enables),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .bus_error (bus_error),
      .dev_valid (dev_valid),
      .dev_ready (dev_ready),
      .dev_rdata (dev_rdata),
      .err_count (err_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level expectation straight from the rules: lowest enable wins,
   // unmapped answers after two cycles, ready on cycle 1+lat answers one cycle later
   // unless the timer already expired.
   function automatic void model(input logic [7:0] en, input int lat,
                                 output logic [7:0] sel, output int resp, output logic err);
      bit found;
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NDEV; i++) begin
         if (en[i] && !found) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
      if (en == 8'h00) begin
         resp = 2;
         err  = 1'b1;
      end else if (lat < TMO) begin
         resp = lat + 2;
         err  = 1'b0;
      end else begin
         resp = TMO + 1;
         err  = 1'b1;
      end
   endfunction

   task automatic run_txn(input vec_t v, input int id);
      logic [31:0] exp_data;
      int          idx;
      int          last;
      bit          aborted;
      aborted  = (v.abort_at > 0);
      idx      = 0;
      for (int i = 0; i < NDEV; i++) if (v.exp_sel[i]) idx = i;
      exp_data = v.exp_err ? ERR : 32'h0;
      last     = aborted ? v.abort_at + 2 : v.exp_resp;
      for (int c = 0; c <= last; c++) begin
         if (c == 0) begin
            chk("err_count", {24'h0, err_count}, model_errs);
            chk("rdata_hold", mem_rdata, last_rdata);
         end
         chk("dev_valid", {24'h0, dev_valid},
             (v.exp_sel != 0 && c >= 1 && c <= (aborted ? v.abort_at : v.exp_resp - 1)) ?
             {24'h0, v.exp_sel} : 32'h0);
         chk("mem_ready", {31'h0, mem_ready}, {31'h0, (!aborted && c == v.exp_resp)});
         chk("bus_error", {31'h0, bus_error}, {31'h0, (!aborted && c == v.exp_resp) ? v.exp_err : 1'b0});
         if (!aborted && c == v.exp_resp) chk("mem_rdata", mem_rdata, exp_data);

         mem_valid = aborted ? (c < v.abort_at) : (c < v.exp_resp);
         enables   = (c == 0) ? v.en : 8'($urandom);
         for (int i = 0; i < NDEV; i++) dev_rdata[32*i +: 32] = $urandom;
         dev_ready = 8'($urandom) & v.noise & ~v.exp_sel;
         if (aborted) begin
            if (c == v.abort_at + 1) dev_ready = dev_ready | v.exp_sel;
         end else if (v.exp_sel != 0 && c == 1 + v.lat) begin
            dev_ready = dev_ready | v.exp_sel;
            if (!v.exp_err) exp_data = dev_rdata[32*idx +: 32];
         end
         step();
      end
      mem_valid = 1'b0;
      dev_ready = '0;
      if (!aborted) begin
         last_rdata = exp_data;
         if (v.exp_err && model_errs < 255) model_errs++;
      end
      $display("txn %0d en=%h sel=%h lat=%0d abort=%0d resp=%0d err=%0b data=%h",
               id, v.en, v.exp_sel, v.lat, v.abort_at, v.exp_resp, v.exp_err, exp_data);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t v;
      tbl[0] = '{8'h01,  0, 0, 8'h00, 8'h01, 2, 1'b0};
      tbl[1] = '{8'h00,  0, 0, 8'hFF, 8'h00, 2, 1'b1};
      tbl[2] = '{8'h04, 99, 0, 8'h00, 8'h04, 5, 1'b1};
      tbl[3] = '{8'h0C,  1, 0, 8'h08, 8'h04, 3, 1'b0};
      tbl[4] = '{8'h01, 99, 1, 8'h00, 8'h01, 0, 1'b0};
      tbl[5] = '{8'h80,  3, 0, 8'h7F, 8'h80, 5, 1'b0};
      tbl[6] = '{8'hFF,  2, 0, 8'hFE, 8'h01, 4, 1'b0};
      tbl[7] = '{8'hA0,  4, 0, 8'h00, 8'h20, 5, 1'b1};
      tbl[8] = '{8'h06,  2, 3, 8'hFF, 8'h02, 0, 1'b0};
      tbl[9] = '{8'h40,  0, 0, 8'hBF, 8'h40, 2, 1'b0};

      reset     = 1'b1;
      mem_valid = 1'b0;
      enables   = '0;
      dev_ready = '0;
      dev_rdata = '0;
      step();
      step();
      chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
      chk("rst_dev_valid", {24'h0, dev_valid}, 32'h0);
      chk("rst_err_count", {24'h0, err_count}, 32'h0);
      reset = 1'b0;
      step();

      for (int t = 0; t < 10; t++) run_txn(tbl[t], t);

      for (int t = 0; t < 200; t++) begin
         v.en       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         v.lat      = $urandom_range(0, 5);
         v.abort_at = (v.en != 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, TMO - 1) : 0;
         v.noise    = 8'($urandom);
         model(v.en, v.lat, v.exp_sel, v.exp_resp, v.exp_err);
         run_txn(v, 100 + t);
      end

      for (int t = 0; t < 300; t++) begin
         v = '{8'h00, 0, 0, 8'h00, 8'h00, 2, 1'b1};
         run_txn(v, 1000 + t);
      end
      chk("err_saturated", {24'h0, err_count}, 32'd255);

      // Reset while a device request is outstanding.
      mem_valid = 1'b1;
      enables   = 8'h02;
      dev_ready = '0;
      step();
      chk("wait_dev_valid", {24'h0, dev_valid}, 32'h02);
      reset = 1'b1;
      #1;
      chk("async_mem_ready", {31'h0, mem_ready}, 32'h0);
      chk("async_mem_rdata", mem_rdata, 32'h0);
      chk("async_bus_error", {31'h0, bus_error}, 32'h0);
      chk("async_dev_valid", {24'h0, dev_valid}, 32'h0);
      chk("async_err_count", {24'h0, err_count}, 32'h0);
      mem_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("post_rst_mem_ready", {31'h0, mem_ready}, 32'h0);
      model_errs = 0;
      last_rdata = 32'h0;
      run_txn(tbl[0], 2000);
      run_txn(tbl[1], 2001);
      step();
      chk("final_err_count", {24'h0, err_count}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
